// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the 68040 bus-cycle region decoder.
//   state_e        : FSM states (IDLE, ACTIVE, ERR)
//   MAX_REGIONS    : widest hit vector onehot_lowest() can process
//   DEFAULT_BASE   : default base addresses, region i in slice i
//   DEFAULT_MASK   : default compare masks, region i in slice i
//   onehot_lowest(): keeps only the lowest set bit of a hit vector
// ----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_e;

    localparam int unsigned MAX_REGIONS = 32'd32;

    // Region 0 = 0000_0000/E000_0000, 1 = F000_0000/FF00_0000,
    // 2 = FF00_0000/FF00_0000, 3 = 8000_0000/C000_0000.
    localparam logic [127:0] DEFAULT_BASE = {32'h8000_0000, 32'hFF00_0000,
                                             32'hF000_0000, 32'h0000_0000};
    localparam logic [127:0] DEFAULT_MASK = {32'hC000_0000, 32'hFF00_0000,
                                             32'hFF00_0000, 32'hE000_0000};

    // Two's-complement trick: vec & -vec isolates the lowest set bit, which
    // gives the lowest-index-wins priority for overlapping windows.
    function automatic logic [MAX_REGIONS-1:0] onehot_lowest(
        input logic [MAX_REGIONS-1:0] vec
    );
        return vec & (~vec + {{(MAX_REGIONS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/region_match.sv
// ----------------------------------------------------------------------------
// region_match
// Combinational base/mask comparator array. Region i hits when
// (addr & MASK[i]) == BASE[i]; several regions may hit at once.
// Ports:
//   addr [ADDR_W-1:0]      in  : address to decode
//   hit  [NUM_REGIONS-1:0] out : per-region match vector
// ----------------------------------------------------------------------------
module region_match #(
    parameter int unsigned                   ADDR_W      = 32,
    parameter int unsigned                   NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] hit
);

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        assign hit[i] = ((addr & REGION_MASK[i*ADDR_W +: ADDR_W])
                         == REGION_BASE[i*ADDR_W +: ADDR_W]);
    end

endmodule

// File: rtl/bus_region_decoder.sv
// ----------------------------------------------------------------------------
// bus_region_decoder
// Registered 68040 bus-cycle address decoder. On an nTS edge in IDLE the
// region hit vector is latched; on the following edge the decoder either
// asserts a one-hot select (ACTIVE) or raises a one-cycle bus error for an
// unmapped address (ERR). The select is held until nTA or nTEA terminates.
// Optional feature macro: BUS_TIMEOUT_EN -- bus error on hung cycles after
// TIMEOUT_CYC cycles in ACTIVE. Without it err_timeout is tied low.
// Ports:
//   BCLK          in  : bus clock, rising edge
//   nRESET        in  : synchronous active-low reset
//   A             in  : CPU address bus [ADDR_W-1:0]
//   nTS           in  : transfer start, active-low
//   nTA           in  : transfer acknowledge, active-low
//   nTEA          in  : transfer error acknowledge, active-low
//   sel           out : one-hot region select [NUM_REGIONS-1:0], registered
//   busy          out : high while a cycle is being tracked
//   nTEA_OUT      out : decoder-generated bus error, active-low pulse
//   err_unmapped  out : pulse, cycle matched no region
//   err_timeout   out : pulse, cycle timed out
// ----------------------------------------------------------------------------
module bus_region_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned                   ADDR_W      = 32,
    parameter int unsigned                   NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_MASK,
    parameter int unsigned                   TIMEOUT_CYC = 64
) (
    input  logic                   BCLK,
    input  logic                   nRESET,
    input  logic [ADDR_W-1:0]      A,
    input  logic                   nTS,
    input  logic                   nTA,
    input  logic                   nTEA,
    output logic [NUM_REGIONS-1:0] sel,
    output logic                   busy,
    output logic                   nTEA_OUT,
    output logic                   err_unmapped,
    output logic                   err_timeout
);

    if ((NUM_REGIONS == 32'd0) || (NUM_REGIONS > MAX_REGIONS)) begin : g_bad_regions
        $error("NUM_REGIONS out of range");
    end
    if (TIMEOUT_CYC < 32'd2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [NUM_REGIONS-1:0] match_s;
    logic                   term_s;

    state_e                 state_q, state_d;
    logic                   pend_q, pend_d;
    logic [NUM_REGIONS-1:0] hit_q, hit_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic                   ntea_out_q, ntea_out_d;
    logic                   err_unmapped_q, err_unmapped_d;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 32'd2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_timeout_q, err_timeout_d;
`endif

    region_match #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_region_match (
        .addr (A),
        .hit  (match_s)
    );

    // nTA and nTEA together count as one ordinary termination.
    assign term_s = (~nTA) | (~nTEA);

    // Next-state and next-output logic for the cycle-tracking FSM.
    always_comb begin
        state_d        = state_q;
        pend_d         = 1'b0;
        hit_d          = hit_q;
        sel_d          = sel_q;
        busy_d         = busy_q;
        ntea_out_d     = 1'b1;
        err_unmapped_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Second edge of a start: act on the latched hit vector.
                    if (|hit_q) begin
                        state_d = ACTIVE;
                        sel_d   = NUM_REGIONS'(onehot_lowest(MAX_REGIONS'(hit_q)));
                        busy_d  = 1'b1;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d        = ERR;
                        sel_d          = '0;
                        busy_d         = 1'b1;
                        ntea_out_d     = 1'b0;
                        err_unmapped_d = 1'b1;
                    end
                end else if (!nTS) begin
                    // Address is decoded only here; later changes are ignored.
                    pend_d = 1'b1;
                    hit_d  = match_s;
                end else begin
                    sel_d  = '0;
                    busy_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (term_s) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 32'd1)) begin
                        state_d       = ERR;
                        sel_d         = '0;
                        busy_d        = 1'b1;
                        ntea_out_d    = 1'b0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ACTIVE;
`endif
                end
            end
            ERR: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge BCLK) begin
        if (!nRESET) begin
            state_q        <= IDLE;
            pend_q         <= 1'b0;
            hit_q          <= '0;
            sel_q          <= '0;
            busy_q         <= 1'b0;
            ntea_out_q     <= 1'b1;
            err_unmapped_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q          <= '0;
            err_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            hit_q          <= hit_d;
            sel_q          <= sel_d;
            busy_q         <= busy_d;
            ntea_out_q     <= ntea_out_d;
            err_unmapped_q <= err_unmapped_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q          <= cnt_d;
            err_timeout_q  <= err_timeout_d;
`endif
        end
    end

    assign sel          = sel_q;
    assign busy         = busy_q;
    assign nTEA_OUT     = ntea_out_q;
    assign err_unmapped = err_unmapped_q;
`ifdef BUS_TIMEOUT_EN
    assign err_timeout  = err_timeout_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_region_decoder.sv
// ----------------------------------------------------------------------------
// tb_bus_region_decoder
// Self-checking bench for bus_region_decoder. A vector table drives decode
// cases through a scoreboard queue; hand-written sequences cover back-to-back
// cycles, hang/timeout, reset and overlapping windows (second instance).
// Honours BUS_TIMEOUT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_bus_region_decoder;

    logic        BCLK = 1'b0;
    logic        nRESET, nTS, nTA, nTEA;
    logic [31:0] A;
    logic [3:0]  sel, sel2;
    logic        busy, nTEA_OUT, err_unmapped, err_timeout;
    logic        busy2, ntea_out2, err_unmapped2, err_timeout2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  exp_sel;
        logic        exp_err;
        int          term;      // 0: nTA, 1: nTEA, 2: both
    } vec_t;

    typedef struct {
        logic [3:0] sel;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    bus_region_decoder dut (
        .BCLK(BCLK), .nRESET(nRESET), .A(A), .nTS(nTS), .nTA(nTA), .nTEA(nTEA),
        .sel(sel), .busy(busy), .nTEA_OUT(nTEA_OUT),
        .err_unmapped(err_unmapped), .err_timeout(err_timeout)
    );

    // Region 1 base moved to 0 so it overlaps region 0 at address 0.
    bus_region_decoder #(
        .REGION_BASE({32'h8000_0000, 32'hFF00_0000, 32'h0000_0000, 32'h0000_0000})
    ) dut2 (
        .BCLK(BCLK), .nRESET(nRESET), .A(A), .nTS(nTS), .nTA(nTA), .nTEA(nTEA),
        .sel(sel2), .busy(busy2), .nTEA_OUT(ntea_out2),
        .err_unmapped(err_unmapped2), .err_timeout(err_timeout2)
    );

    always #5 BCLK = ~BCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start a cycle, push the expected result, then pop it when busy rises.
    task automatic issue(input logic [31:0] addr, input logic [3:0] esel, input logic eerr);
        exp_t e;
        int   lat;
        @(negedge BCLK);
        A   = addr;
        nTS = 1'b0;
        e.sel = esel;
        e.err = eerr;
        sb_q.push_back(e);
        @(negedge BCLK);
        nTS = 1'b1;
        A   = ~addr;
        chk("latency_sel", 32'(sel), 32'h0);
        chk("latency_busy", 32'(busy), 32'h0);
        lat = 0;
        while (busy !== 1'b1 && lat < 8) begin
            @(negedge BCLK);
            lat++;
        end
        chk("latency_cycles", 32'(lat), 32'd1);
        e = sb_q.pop_front();
        chk("sel", 32'(sel), 32'(e.sel));
        chk("err_unmapped", 32'(err_unmapped), 32'(e.err));
        chk("ntea_out", 32'(nTEA_OUT), 32'(!e.err));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        logic held;

        vecs[0] = '{32'h0010_0000, 4'b0001, 1'b0, 0};
        vecs[1] = '{32'hF012_3456, 4'b0010, 1'b0, 1};
        vecs[2] = '{32'hFF00_0010, 4'b0100, 1'b0, 2};
        vecs[3] = '{32'h9000_0000, 4'b1000, 1'b0, 0};
        vecs[4] = '{32'h4000_0000, 4'b0000, 1'b1, 0};
        vecs[5] = '{32'h1FFF_FFFF, 4'b0001, 1'b0, 1};
        vecs[6] = '{32'h2000_0000, 4'b0000, 1'b1, 0};
        vecs[7] = '{32'hBFFF_FFFF, 4'b1000, 1'b0, 2};
        vecs[8] = '{32'hF0FF_FFFF, 4'b0010, 1'b0, 0};
        vecs[9] = '{32'hEFFF_FFFF, 4'b0000, 1'b1, 0};

        nRESET = 1'b0; nTS = 1'b1; nTA = 1'b1; nTEA = 1'b1; A = 32'h0;
        @(negedge BCLK);
        @(negedge BCLK);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ntea_out", 32'(nTEA_OUT), 32'h1);
        chk("reset_err_unmapped", 32'(err_unmapped), 32'h0);
        chk("reset_err_timeout", 32'(err_timeout), 32'h0);
        chk("reset_sel2", 32'(sel2), 32'h0);
        chk("reset_busy2", 32'(busy2), 32'h0);
        chk("reset_ntea_out2", 32'(ntea_out2), 32'h1);
        chk("reset_err2", 32'({err_unmapped2, err_timeout2}), 32'h0);
        nRESET = 1'b1;

        // Table-driven decode, hold, stray nTS and termination checks.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].addr, vecs[i].exp_sel, vecs[i].exp_err);
            if (!vecs[i].exp_err) begin
                for (int k = 0; k < 3; k++) begin
                    nTS = (k == 0) ? 1'b0 : 1'b1;
                    A   = 32'h4000_0000;
                    @(negedge BCLK);
                    chk("hold_sel", 32'(sel), 32'(vecs[i].exp_sel));
                    chk("hold_ntea_out", 32'(nTEA_OUT), 32'h1);
                end
                nTS  = 1'b1;
                nTA  = (vecs[i].term != 1) ? 1'b0 : 1'b1;
                nTEA = (vecs[i].term != 0) ? 1'b0 : 1'b1;
                @(negedge BCLK);
                chk("term_sel", 32'(sel), 32'h0);
                chk("term_busy", 32'(busy), 32'h0);
                chk("term_ntea_out", 32'(nTEA_OUT), 32'h1);
                nTA  = 1'b1;
                nTEA = 1'b1;
                @(negedge BCLK);
                chk("idle_ntea_out", 32'(nTEA_OUT), 32'h1);
                chk("idle_busy", 32'(busy), 32'h0);
            end else begin
                chk("err_sel", 32'(sel), 32'h0);
                chk("err_busy", 32'(busy), 32'h1);
                @(negedge BCLK);
                chk("err_end_ntea_out", 32'(nTEA_OUT), 32'h1);
                chk("err_end_unmapped", 32'(err_unmapped), 32'h0);
                chk("err_end_busy", 32'(busy), 32'h0);
            end
        end

        // Back-to-back: nTA sampled at N, new nTS sampled at N+1.
        issue(32'h0010_0000, 4'b0001, 1'b0);
        nTA = 1'b0;
        @(negedge BCLK);
        chk("b2b_drop", 32'(sel), 32'h0);
        nTA = 1'b1;
        A   = 32'hF000_0000;
        nTS = 1'b0;
        @(negedge BCLK);
        nTS = 1'b1;
        chk("b2b_latency", 32'(sel), 32'h0);
        @(negedge BCLK);
        chk("b2b_sel", 32'(sel), 32'h2);
        chk("b2b_busy", 32'(busy), 32'h1);
        nTA = 1'b0;
        @(negedge BCLK);
        nTA = 1'b1;
        chk("b2b_end", 32'(sel), 32'h0);

        // Hung cycle: no termination from the target.
        issue(32'h0000_0000, 4'b0001, 1'b0);
`ifdef BUS_TIMEOUT_EN
        cyc = 0;
        while (nTEA_OUT !== 1'b0 && cyc < 100) begin
            @(negedge BCLK);
            cyc++;
        end
        chk("timeout_cycles", 32'(cyc), 32'd64);
        chk("timeout_flag", 32'(err_timeout), 32'h1);
        chk("timeout_sel", 32'(sel), 32'h0);
        @(negedge BCLK);
        chk("timeout_end_ntea", 32'(nTEA_OUT), 32'h1);
        chk("timeout_end_flag", 32'(err_timeout), 32'h0);
        chk("timeout_end_busy", 32'(busy), 32'h0);
`else
        held = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge BCLK);
            if (sel !== 4'b0001 || nTEA_OUT !== 1'b1 || err_timeout !== 1'b0) held = 1'b0;
        end
        chk("hold_200", 32'(held), 32'h1);
        nTA = 1'b0;
        @(negedge BCLK);
        nTA = 1'b1;
        chk("hold_200_end", 32'(sel), 32'h0);
`endif

        // Reset mid-ACTIVE, and nTS while reset is held.
        issue(32'h9000_0000, 4'b1000, 1'b0);
        nRESET = 1'b0;
        @(negedge BCLK);
        chk("rst_mid_sel", 32'(sel), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        A   = 32'h0;
        nTS = 1'b0;
        @(negedge BCLK);
        nTS = 1'b1;
        @(negedge BCLK);
        @(negedge BCLK);
        chk("rst_nts_sel", 32'(sel), 32'h0);
        nRESET = 1'b1;
        @(negedge BCLK);
        @(negedge BCLK);
        chk("rst_release_sel", 32'(sel), 32'h0);
        chk("rst_release_busy", 32'(busy), 32'h0);

        // Overlapping windows: lowest index wins.
        issue(32'h0000_0000, 4'b0001, 1'b0);
        chk("overlap_sel2", 32'(sel2), 32'h1);
        nTA = 1'b0;
        @(negedge BCLK);
        nTA = 1'b1;
        chk("overlap_end_sel2", 32'(sel2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
